// File: rtl/itf_pkg.sv
// Shared definitions for the off-chip port controller: FSM encoding,
// command-word field layout and DMA direction codes.
package itf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_CMD  = 3'd2,
        ST_IN   = 3'd3,
        ST_OUT  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    // Command word layout: {zero pad, len, addr, dir}
    localparam int CMD_DIR_BIT         = 0;
    localparam int CMD_ADDR_LSB        = 1;
    localparam int DEF_DRAM_ADDR_WIDTH = 32;
    localparam int CMD_LEN_LSB         = CMD_ADDR_LSB + DEF_DRAM_ADDR_WIDTH;

    localparam logic DIR_IN  = 1'b0;
    localparam logic DIR_OUT = 1'b1;

    // Length field offset for a non-default address width.
    function automatic int cmd_len_lsb(input int addr_w);
        return CMD_ADDR_LSB + addr_w;
    endfunction

endpackage

// File: rtl/itf_port_ctrl_cnt.sv
// Remaining-beat counter: loads a default value, decrements on each beat
// and saturates at zero so it never wraps.
module itf_port_ctrl_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_default,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_default;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/itf_port_ctrl.sv
// Chip-side controller for the off-chip data port: grants ISA configuration
// to one operator at a time and runs DMA command/data transfers.
module itf_port_ctrl
    import itf_pkg::*;
#(
    parameter int PORT_WIDTH      = 128,
    parameter int DRAM_ADDR_WIDTH = 32,
    parameter int OPNUM           = 6,
    parameter int LEN_WIDTH       = 16,
    localparam int IDX_W          = (OPNUM > 1) ? $clog2(OPNUM) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic [OPNUM-1:0]           O_CfgRdy,
    input  logic                       I_ISAVld,
    output logic                       O_DatOE,
    output logic                       O_CmdVld,
    input  logic [PORT_WIDTH-1:0]      I_Dat,
    output logic [PORT_WIDTH-1:0]      O_Dat,
    input  logic                       I_DatVld,
    output logic                       O_DatVld,
    input  logic                       I_DatRdy,
    output logic                       O_DatRdy,
    input  logic [OPNUM-1:0]           I_CfgReq,
    input  logic [OPNUM-1:0]           I_CfgDone,
    output logic                       O_IsaVld,
    output logic [PORT_WIDTH-1:0]      O_IsaDat,
    output logic [IDX_W-1:0]           O_IsaIdx,
    input  logic                       I_IsaRdy,
    input  logic                       I_DmaReqVld,
    output logic                       O_DmaReqRdy,
    input  logic                       I_DmaDir,
    input  logic [DRAM_ADDR_WIDTH-1:0] I_DmaAddr,
    input  logic [LEN_WIDTH-1:0]       I_DmaLen,
    output logic [PORT_WIDTH-1:0]      O_RdDat,
    output logic                       O_RdVld,
    input  logic                       I_RdRdy,
    input  logic [PORT_WIDTH-1:0]      I_WrDat,
    input  logic                       I_WrVld,
    output logic                       O_WrRdy,
    output logic                       O_DmaDone
);

    localparam int LEN_LSB = cmd_len_lsb(DRAM_ADDR_WIDTH);

    state_e                     r_state;
    state_e                     w_state_next;
    logic                       r_req_rdy;
    logic [IDX_W-1:0]           r_grant;
    logic                       r_dir;
    logic [DRAM_ADDR_WIDTH-1:0] r_addr;
    logic [LEN_WIDTH-1:0]       r_len;

    logic [IDX_W-1:0]           w_grant_enc;
    logic [OPNUM-1:0]           w_grant_oh;
    logic [PORT_WIDTH-1:0]      w_cmd;
    logic                       w_cnt_load;
    logic                       w_beat;
    logic [LEN_WIDTH-1:0]       w_cnt;
    logic                       w_dma_acc;
    logic                       w_cfg_acc;

    // Lowest requesting operator wins the grant.
    always_comb begin
        w_grant_enc = '0;
        for (int i = OPNUM - 1; i >= 0; i--) begin
            if (I_CfgReq[i]) begin
                w_grant_enc = IDX_W'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < OPNUM; gi++) begin : g_grant_oh
            assign w_grant_oh[gi] = (r_grant == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        w_cmd = '0;
        w_cmd[CMD_DIR_BIT]                     = r_dir;
        w_cmd[CMD_ADDR_LSB +: DRAM_ADDR_WIDTH] = r_addr;
        w_cmd[LEN_LSB +: LEN_WIDTH]            = r_len;
    end

    assign w_dma_acc  = (r_state == ST_IDLE) && r_req_rdy && I_DmaReqVld;
    assign w_cfg_acc  = (r_state == ST_IDLE) && r_req_rdy && !I_DmaReqVld && (|I_CfgReq);
    assign w_cnt_load = (r_state == ST_CMD) && I_DatRdy;

    always_comb begin
        w_beat = 1'b0;
        if (r_state == ST_IN) begin
            w_beat = I_DatVld && I_RdRdy;
        end else if (r_state == ST_OUT) begin
            w_beat = I_WrVld && I_DatRdy;
        end
    end

    itf_port_ctrl_cnt #(
        .WIDTH (LEN_WIDTH)
    ) u_beat_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_cnt_load),
        .i_default (r_len),
        .i_dec     (w_beat),
        .o_cnt     (w_cnt)
    );

    // Ready is held low for the first cycle after reset so that every
    // output reads zero while and directly after reset is applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_req_rdy <= 1'b0;
            r_grant   <= '0;
            r_dir     <= 1'b0;
            r_addr    <= '0;
            r_len     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_req_rdy <= (w_state_next == ST_IDLE);
            if (w_dma_acc) begin
                r_dir  <= I_DmaDir;
                r_addr <= I_DmaAddr;
                r_len  <= I_DmaLen;
            end else if (w_cfg_acc) begin
                r_grant <= w_grant_enc;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        O_CfgRdy     = '0;
        O_DatOE      = 1'b0;
        O_CmdVld     = 1'b0;
        O_Dat        = '0;
        O_DatVld     = 1'b0;
        O_DatRdy     = 1'b0;
        O_IsaVld     = 1'b0;
        O_IsaDat     = '0;
        O_IsaIdx     = '0;
        O_DmaReqRdy  = 1'b0;
        O_RdDat      = '0;
        O_RdVld      = 1'b0;
        O_WrRdy      = 1'b0;
        O_DmaDone    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                O_DmaReqRdy = r_req_rdy;
                if (w_dma_acc) begin
                    w_state_next = ST_CMD;
                end else if (w_cfg_acc) begin
                    w_state_next = ST_CFG;
                end
            end
            ST_CFG: begin
                O_CfgRdy = w_grant_oh;
                O_DatRdy = I_ISAVld && I_IsaRdy;
                O_IsaVld = I_ISAVld && I_DatVld;
                O_IsaDat = I_Dat;
                O_IsaIdx = r_grant;
                if (I_CfgDone[r_grant]) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_CMD: begin
                O_DatOE  = 1'b1;
                O_CmdVld = 1'b1;
                O_DatVld = 1'b1;
                O_Dat    = w_cmd;
                if (I_DatRdy) begin
                    if (r_len == '0) begin
                        w_state_next = ST_DONE;
                    end else if (r_dir == DIR_OUT) begin
                        w_state_next = ST_OUT;
                    end else begin
                        w_state_next = ST_IN;
                    end
                end
            end
            ST_IN: begin
                O_DatRdy = I_RdRdy;
                O_RdVld  = I_DatVld;
                O_RdDat  = I_Dat;
                if (w_beat && (w_cnt <= LEN_WIDTH'(1))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_OUT: begin
                O_DatOE  = 1'b1;
                O_DatVld = I_WrVld;
                O_Dat    = I_WrDat;
                O_WrRdy  = I_DatRdy;
                if (w_beat && (w_cnt <= LEN_WIDTH'(1))) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                O_DmaDone    = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule
